// File: rtl/hs_tx_serializer_pkg.sv
// Shared definitions for the HS transmit lane: burst state encoding and default framing constants.
package hs_tx_serializer_pkg;

    localparam int         DATA_WIDTH_DEF   = 8;
    localparam logic [7:0] SYNC_PATTERN_DEF = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ZERO  = 3'd1,
        ST_SYNC  = 3'd2,
        ST_DATA  = 3'd3,
        ST_TRAIL = 3'd4
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/hs_tx_shift_reg.sv
// Byte shifter: holds the bits of the current byte not yet on the line, plus a count of bits already driven.
module hs_tx_shift_reg
    import hs_tx_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] d,
    output logic                  q0,
    output logic                  last_bit_flag
);

    localparam int             BW      = $clog2(DATA_WIDTH) + 1;
    localparam logic [BW-1:0]  NEXT_LAST = BW'(DATA_WIDTH - 2);

    logic [DATA_WIDTH-1:0] sr_q;
    logic [BW-1:0]         cnt_q;

    // Bit 0 of a loaded byte goes straight to the line, so only the upper bits are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (load) begin
            sr_q  <= d >> 1;
            cnt_q <= '0;
        end else if (shift) begin
            sr_q  <= sr_q >> 1;
            cnt_q <= cnt_q + BW'(1);
        end else begin
            sr_q  <= sr_q;
            cnt_q <= cnt_q;
        end
    end

    assign q0            = sr_q[0];
    assign last_bit_flag = (cnt_q == NEXT_LAST);

endmodule

// File: rtl/hs_tx_serializer.sv
// HS lane transmitter: frames PPI bytes as zero preamble, sync byte, LSB-first payload and inverted trailer.
module hs_tx_serializer
    import hs_tx_serializer_pkg::*;
#(
    parameter int                    DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int                    ZERO_LEN     = 8,
    parameter int                    TRAIL_LEN    = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_PATTERN = DATA_WIDTH'(SYNC_PATTERN_DEF)
) (
    input  logic                  TxDDRClkHS,
    input  logic                  RST,
    input  logic                  TxRequestHS,
    input  logic [DATA_WIDTH-1:0] TxDataHS,
    output logic                  TxReadyHS,
    output logic                  TxActiveHS,
    output logic                  HS_TX_DATA
);

    localparam int               CNT_W      = $clog2(max3(ZERO_LEN, TRAIL_LEN, DATA_WIDTH)) + 1;
    localparam logic [CNT_W-1:0] ZERO_LAST  = CNT_W'(ZERO_LEN - 1);
    localparam logic [CNT_W-1:0] TRAIL_LAST = CNT_W'(TRAIL_LEN - 1);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  last_q, last_d;
    logic                  line_q, line_d;
    logic                  active_q, active_d;
    logic                  ready_q, ready_d;
    logic                  sr_load, sr_shift, sr_q0, sr_last;
    logic [DATA_WIDTH-1:0] sr_din;

    hs_tx_shift_reg #(.DATA_WIDTH(DATA_WIDTH)) u_shift (
        .clk           (TxDDRClkHS),
        .rst_n         (RST),
        .load          (sr_load),
        .shift         (sr_shift),
        .d             (sr_din),
        .q0            (sr_q0),
        .last_bit_flag (sr_last)
    );

    // Next-state and next-output decode; outputs describe the cycle after the coming edge.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        last_d   = last_q;
        line_d   = 1'b0;
        active_d = 1'b1;
        ready_d  = 1'b0;
        sr_load  = 1'b0;
        sr_shift = 1'b0;
        sr_din   = SYNC_PATTERN;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (TxRequestHS) begin
                    state_d = ST_ZERO;
                end else begin
                    active_d = 1'b0;
                end
            end
            ST_ZERO: begin
                if (cnt_q == ZERO_LAST) begin
                    state_d = ST_SYNC;
                    cnt_d   = '0;
                    sr_load = 1'b1;
                    line_d  = SYNC_PATTERN[0];
                    last_d  = SYNC_PATTERN[0];
                end else begin
                    line_d = 1'b0;
                end
            end
            ST_SYNC, ST_DATA: begin
                cnt_d = '0;
                if (ready_q && TxRequestHS) begin
                    state_d = ST_DATA;
                    sr_load = 1'b1;
                    sr_din  = TxDataHS;
                    line_d  = TxDataHS[0];
                    last_d  = TxDataHS[0];
                end else if (ready_q) begin
                    state_d = ST_TRAIL;
                    line_d  = ~last_q;
                end else begin
                    sr_shift = 1'b1;
                    line_d   = sr_q0;
                    last_d   = sr_q0;
                    ready_d  = sr_last;
                end
            end
            ST_TRAIL: begin
                if (cnt_q == TRAIL_LAST) begin
                    state_d  = ST_IDLE;
                    cnt_d    = '0;
                    active_d = 1'b0;
                end else begin
                    line_d = ~last_q;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                active_d = 1'b0;
            end
        endcase
    end

    // State, counter and registered lane outputs; reset aborts a burst with no trailer.
    always_ff @(posedge TxDDRClkHS or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b0;
            line_q   <= 1'b0;
            active_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            last_q   <= last_d;
            line_q   <= line_d;
            active_q <= active_d;
            ready_q  <= ready_d;
        end
    end

    assign TxReadyHS  = ready_q;
    assign TxActiveHS = active_q;
    assign HS_TX_DATA = line_q;

endmodule

// File: tb/tb_hs_tx_serializer.sv
// Randomized bench for hs_tx_serializer: expected line/active/ready traces are built per burst from the framing rules.
module tb_hs_tx_serializer;

    localparam int         ZL   = 8;
    localparam int         TL   = 8;
    localparam logic [7:0] SYNC = 8'hB8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req;
    logic [7:0] data;
    logic       rdy, act, line;

    int n_checks = 0;
    int n_fail   = 0;

    hs_tx_serializer #(.DATA_WIDTH(8), .ZERO_LEN(ZL), .TRAIL_LEN(TL), .SYNC_PATTERN(SYNC)) dut (
        .TxDDRClkHS  (clk),
        .RST         (rst_n),
        .TxRequestHS (req),
        .TxDataHS    (data),
        .TxReadyHS   (rdy),
        .TxActiveHS  (act),
        .HS_TX_DATA  (line)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_line"}, {31'd0, line}, 32'd0);
        check({tag, "_act"},  {31'd0, act},  32'd0);
        check({tag, "_rdy"},  {31'd0, rdy},  32'd0);
    endtask

    // Expects req=1 already set ahead of the first edge; leaves req = b2b after the trailing idle cycle.
    task automatic run_burst(input logic [7:0] bytes[$], input int abort_at, input bit b2b);
        logic [7:0] pat[$];
        bit         e_line[$], e_act[$], e_rdy[$];
        logic [7:0] cur;
        bit         lastb;
        int         k;
        lastb = 1'b0;
        for (int i = 0; i < ZL; i++) begin
            e_line.push_back(1'b0); e_act.push_back(1'b1); e_rdy.push_back(1'b0);
        end
        pat = bytes;
        pat.push_front(SYNC);
        foreach (pat[j]) begin
            cur = pat[j];
            for (int i = 0; i < 8; i++) begin
                e_line.push_back(cur[i]); e_act.push_back(1'b1); e_rdy.push_back(i == 7);
            end
            lastb = cur[7];
        end
        for (int i = 0; i < TL; i++) begin
            e_line.push_back(~lastb); e_act.push_back(1'b1); e_rdy.push_back(1'b0);
        end
        e_line.push_back(1'b0); e_act.push_back(1'b0); e_rdy.push_back(1'b0);

        k = 0;
        for (int t = 0; t < e_line.size(); t++) begin
            @(posedge clk);
            #1;
            check($sformatf("line@%0d", t), {31'd0, line}, {31'd0, e_line[t]});
            check($sformatf("act@%0d", t),  {31'd0, act},  {31'd0, e_act[t]});
            check($sformatf("rdy@%0d", t),  {31'd0, rdy},  {31'd0, e_rdy[t]});
            if (t == abort_at) begin
                #2 rst_n = 1'b0;
                #1 check_quiet("async_rst");
                req = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            data = 8'($urandom);
            if (e_rdy[t]) begin
                if (k < bytes.size()) begin
                    req  = 1'b1;
                    data = bytes[k];
                    k++;
                end else begin
                    req = 1'b0;
                end
            end else if (t == e_line.size() - 1) begin
                req = b2b;
            end else begin
                req = 1'($urandom % 2);
            end
        end
    endtask

    task automatic idle_gap(input int n);
        req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check_quiet("idle");
        end
        req = 1'b1;
    endtask

    initial begin
        logic [7:0] q[$];
        int         nb;
        bit         b2b;
        rst_n = 1'b0;
        req   = 1'b0;
        data  = 8'h00;
        #12;
        check_quiet("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_quiet("post_reset");
        @(negedge clk);
        req = 1'b1;

        q = {8'hA5};
        run_burst(q, -1, 1'b0);
        idle_gap(2);
        q = {8'h01, 8'hFF, 8'h80};
        run_burst(q, -1, 1'b1);
        q = {8'h7F};
        run_burst(q, -1, 1'b0);
        idle_gap(1);
        q = {};
        run_burst(q, -1, 1'b0);
        idle_gap(1);
        q = {8'h11, 8'h22, 8'h33};
        run_burst(q, ZL + 8 + 3, 1'b0);
        idle_gap(1);

        for (int r = 0; r < 20; r++) begin
            q  = {};
            nb = $urandom_range(0, 4);
            for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
            b2b = (r == 19) ? 1'b0 : 1'($urandom % 2);
            run_burst(q, -1, b2b);
            if (!b2b && r != 19) idle_gap($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
